// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the N-master SDRAM arbiter.
// Tags carry the issuing master and the beats still owed to it.
package sdram_arb_pkg;

  localparam int ARB_MAX_M     = 16;
  localparam int ARB_ID_W      = $clog2(ARB_MAX_M);
  localparam int ARB_MAX_BURST = 16;
  localparam int ARB_BEATS_W   = $clog2(ARB_MAX_BURST + 1);

  typedef struct packed {
    logic [ARB_ID_W-1:0]    id;
    logic [ARB_BEATS_W-1:0] beats;
  } arb_tag_t;

  // Walks n requesters from ptr, wrapping modulo n (n need not be 2^k).
  function automatic logic [ARB_MAX_M-1:0] rr_pick(
    input logic [ARB_MAX_M-1:0] req,
    input int unsigned          ptr,
    input int unsigned          n
  );
    logic [ARB_MAX_M-1:0] g;
    logic                 found;
    int unsigned          idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < ARB_MAX_M; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[ARB_ID_W-1:0]]) begin
          g[idx[ARB_ID_W-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Outstanding-read tag FIFO; head is the read whose beats arrive next.
// Pointers wrap explicitly so a depth of one also works.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  arb_tag_t               tag_i,
  input  logic                   pop_i,
  output arb_tag_t               head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  arb_tag_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   w_wr_nxt;
  logic [AW-1:0]   w_rd_nxt;

  always_comb begin
    w_wr_nxt = (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
    w_rd_nxt = (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr] <= tag_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push_i) r_wr <= w_wr_nxt;
      if (pop_i)  r_rd <= w_rd_nxt;
      unique case ({push_i, pop_i})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign head_o  = r_mem[r_rd];
  assign count_o = r_cnt;

endmodule

// File: rtl/sdram_arbiter_n.sv
// N-master SDRAM command arbiter: promoted > high-priority > round-robin,
// with tagged read tracking that steers (burst) responses to their issuer.
module sdram_arbiter_n
  import sdram_arb_pkg::*;
#(
  parameter int               NUM_M        = 3,
  parameter int               ADDR_W       = 24,
  parameter int               DATA_W       = 16,
  parameter logic [NUM_M-1:0] HIPRI_MASK   = 3'b010,
  parameter int               BURST_LEN    = 8,
  parameter int               MAX_OUTST    = 4,
  parameter int               STARVE_LIMIT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_M-1:0]         m_cmd_valid_i,
  output logic [NUM_M-1:0]         m_cmd_ready_o,
  input  logic [NUM_M-1:0]         m_rd_i,
  input  logic [NUM_M-1:0]         m_wr_i,
  input  logic [NUM_M-1:0]         m_burst_i,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr_i,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata_i,
  input  logic [NUM_M*2-1:0]       m_wmask_i,
  output logic [NUM_M-1:0]         m_resp_valid_o,
  output logic [DATA_W-1:0]        m_rdata_o,
  output logic                     sdram_cmd_valid_o,
  output logic                     sdram_rd_o,
  output logic                     sdram_wr_o,
  output logic                     sdram_burst_o,
  output logic [ADDR_W-1:0]        sdram_addr_o,
  output logic [DATA_W-1:0]        sdram_wdata_o,
  output logic [1:0]               sdram_wmask_o,
  input  logic                     sdram_cmd_ready_i,
  input  logic                     sdram_resp_valid_i,
  input  logic [DATA_W-1:0]        sdram_rdata_i,
  output logic                     err_o
);

  localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTST);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [PW-1:0]          r_ptr;
  logic [SW-1:0]          r_starve [NUM_M];
  logic [ARB_BEATS_W-1:0] r_beat;
  logic [NUM_M-1:0]       r_resp_valid;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_err;

  logic [NUM_M-1:0]       w_elig;
  logic [NUM_M-1:0]       w_prom;
  logic [NUM_M-1:0]       w_hi;
  logic [NUM_M-1:0]       w_rr;
  logic [NUM_M-1:0]       w_grant;
  logic [ARB_MAX_M-1:0]   w_rr_req;
  logic [ARB_MAX_M-1:0]   w_rr_pick;
  logic [ARB_ID_W-1:0]    w_gidx;
  logic [PW-1:0]          w_ptr_nxt;
  logic                   w_acc;
  logic                   w_rr_win;
  logic                   w_rdwr;
  logic                   w_resp_hit;
  logic                   w_push;
  logic                   w_pop;
  arb_tag_t               w_push_tag;
  arb_tag_t               w_head;
  logic [CW-1:0]          w_count;

  // Room is judged on the cycle-start count, so a push can never overflow.
  always_comb begin
    w_elig = '0;
    w_prom = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_elig[i] = ~rst_i & m_cmd_valid_i[i] &
                  (m_wr_i[i] | (w_count < MAX_CNT));
      w_prom[i] = w_elig[i] & ~HIPRI_MASK[i] &
                  (r_starve[i] == STARVE_MAX);
    end
    w_hi     = w_elig & HIPRI_MASK;
    w_rr     = w_elig & ~HIPRI_MASK;
    w_rr_req = ARB_MAX_M'(w_rr);
  end

  always_comb begin
    w_rr_pick = rr_pick(w_rr_req, 32'(r_ptr), NUM_M);
    w_grant   = '0;
    w_rr_win  = 1'b0;
    if (|w_prom) begin
      for (int i = NUM_M - 1; i >= 0; i--)
        if (w_prom[i]) begin
          w_grant    = '0;
          w_grant[i] = 1'b1;
        end
      w_rr_win = 1'b1;
    end else if (|w_hi) begin
      for (int i = NUM_M - 1; i >= 0; i--)
        if (w_hi[i]) begin
          w_grant    = '0;
          w_grant[i] = 1'b1;
        end
    end else begin
      w_grant  = w_rr_pick[NUM_M-1:0];
      w_rr_win = |w_rr;
    end
  end

  always_comb begin
    w_gidx        = '0;
    sdram_rd_o    = 1'b0;
    sdram_wr_o    = 1'b0;
    sdram_burst_o = 1'b0;
    sdram_addr_o  = '0;
    sdram_wdata_o = '0;
    sdram_wmask_o = '0;
    for (int i = 0; i < NUM_M; i++)
      if (w_grant[i]) begin
        w_gidx        = ARB_ID_W'(i);
        sdram_wr_o    = m_wr_i[i];
        sdram_rd_o    = m_rd_i[i] & ~m_wr_i[i];
        sdram_burst_o = m_burst_i[i];
        sdram_addr_o  = m_addr_i[i*ADDR_W +: ADDR_W];
        sdram_wdata_o = m_wdata_i[i*DATA_W +: DATA_W];
        sdram_wmask_o = m_wmask_i[i*2 +: 2];
      end
  end

  assign sdram_cmd_valid_o = |w_elig;
  assign m_cmd_ready_o     = w_grant & {NUM_M{sdram_cmd_ready_i}};
  assign w_acc             = sdram_cmd_valid_o & sdram_cmd_ready_i;
  assign w_rdwr            = |(w_grant & m_rd_i & m_wr_i);
  assign w_push            = w_acc & sdram_rd_o;
  assign w_push_tag.id     = w_gidx;
  assign w_push_tag.beats  = sdram_burst_o ? ARB_BEATS_W'(BURST_LEN)
                                           : ARB_BEATS_W'(1);
  assign w_resp_hit        = sdram_resp_valid_i & (w_count != '0);
  assign w_pop             = w_resp_hit &
                             (r_beat == w_head.beats - ARB_BEATS_W'(1));
  assign w_ptr_nxt         = (32'(w_gidx) == NUM_M - 1) ? '0
                             : PW'(w_gidx) + PW'(1);

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tags (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .tag_i   (w_push_tag),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .count_o (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_acc && w_rr_win) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_M; i++) begin
      if (rst_i || HIPRI_MASK[i] || m_cmd_ready_o[i])
        r_starve[i] <= '0;
      else if (m_cmd_valid_i[i] && r_starve[i] != STARVE_MAX)
        r_starve[i] <= r_starve[i] + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_beat       <= '0;
      r_resp_valid <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      if (w_resp_hit) begin
        for (int i = 0; i < NUM_M; i++)
          r_resp_valid[i] <= (32'(w_head.id) == i);
        r_rdata <= sdram_rdata_i;
        r_beat  <= w_pop ? '0 : r_beat + ARB_BEATS_W'(1);
      end
      if ((sdram_resp_valid_i && !w_resp_hit) || (w_acc && w_rdwr))
        r_err <= 1'b1;
    end
  end

  assign m_resp_valid_o = r_resp_valid;
  assign m_rdata_o      = r_rdata;
  assign err_o          = r_err;

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Directed bench for sdram_arbiter_n with default parameters.
module tb_sdram_arbiter_n;

  localparam int NM = 3;
  localparam int AW = 24;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]   vld, rd, wr, bst;
  logic [NM*AW-1:0] addr;
  logic [NM*DW-1:0] wdata;
  logic [NM*2-1:0] wmask;
  logic [NM-1:0]   m_rdy, m_rsp;
  logic [DW-1:0]   m_rdata;
  logic            s_vld, s_rd, s_wr, s_bst;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [1:0]      s_wmask;
  logic            s_rdy, s_rsp;
  logic [DW-1:0]   s_rdata;
  logic            err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;

  always #5 clk = ~clk;

  sdram_arbiter_n dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .m_cmd_valid_i      (vld),
    .m_cmd_ready_o      (m_rdy),
    .m_rd_i             (rd),
    .m_wr_i             (wr),
    .m_burst_i          (bst),
    .m_addr_i           (addr),
    .m_wdata_i          (wdata),
    .m_wmask_i          (wmask),
    .m_resp_valid_o     (m_rsp),
    .m_rdata_o          (m_rdata),
    .sdram_cmd_valid_o  (s_vld),
    .sdram_rd_o         (s_rd),
    .sdram_wr_o         (s_wr),
    .sdram_burst_o      (s_bst),
    .sdram_addr_o       (s_addr),
    .sdram_wdata_o      (s_wdata),
    .sdram_wmask_o      (s_wmask),
    .sdram_cmd_ready_i  (s_rdy),
    .sdram_resp_valid_i (s_rsp),
    .sdram_rdata_i      (s_rdata),
    .err_o              (err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    vld = '0;
    rd  = '0;
    wr  = '0;
    bst = '0;
  endtask

  task automatic cmd(input int m, input logic r, input logic w,
                     input logic b, input logic [AW-1:0] a);
    vld[m] = 1'b1;
    rd[m]  = r;
    wr[m]  = w;
    bst[m] = b;
    addr[m*AW +: AW]  = a;
    wdata[m*DW +: DW] = 16'h5A00 + 16'(m);
    wmask[m*2 +: 2]   = 2'b11;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    addr = '0; wdata = '0; wmask = '0;
    s_rdy = 1'b0; s_rsp = 1'b0; s_rdata = '0;
    step();
    step();
    // reset: outputs stay low even with a request pending
    cmd(0, 1'b1, 1'b0, 1'b0, 24'h000010);
    s_rdy = 1'b1;
    #1;
    chk("rst_cmd_valid", 32'(s_vld), 0);
    chk("rst_ready", 32'(m_rdy), 0);
    chk("rst_resp", 32'(m_rsp), 0);
    chk("rst_err", 32'(err), 0);
    clr();
    rst = 1'b0;
    step();

    // 1: single read from master 2
    cmd(2, 1'b1, 1'b0, 1'b0, 24'h000100);
    #1;
    chk("t1_ready", 32'(m_rdy), 32'b100);
    chk("t1_addr", 32'(s_addr), 32'h100);
    chk("t1_rd", 32'(s_rd), 1);
    step();
    clr();
    repeat (4) step();
    s_rsp = 1'b1; s_rdata = 16'hBEEF;
    #1;
    chk("t1_resp_early", 32'(m_rsp), 0);
    step();
    s_rsp = 1'b0;
    #1;
    chk("t1_resp", 32'(m_rsp), 32'b100);
    chk("t1_rdata", 32'(m_rdata), 32'hBEEF);
    chk("t1_err", 32'(err), 0);
    step();
    chk("t1_resp_done", 32'(m_rsp), 0);

    // 2: round-robin 0/2 alternate, HIPRI 1 cuts in
    cmd(0, 1'b0, 1'b1, 1'b0, 24'h000020);
    cmd(2, 1'b0, 1'b1, 1'b0, 24'h000022);
    #1;
    chk("t2_g0", 32'(m_rdy), 32'b001);
    step();
    chk("t2_g1", 32'(m_rdy), 32'b100);
    step();
    chk("t2_g2", 32'(m_rdy), 32'b001);
    step();
    chk("t2_g3", 32'(m_rdy), 32'b100);
    step();
    cmd(1, 1'b0, 1'b1, 1'b0, 24'h000021);
    #1;
    chk("t2_hipri", 32'(m_rdy), 32'b010);
    step();
    vld[1] = 1'b0; wr[1] = 1'b0;
    #1;
    chk("t2_after_hi", 32'(m_rdy), 32'b001);
    step();
    clr();

    // 3: burst to master 1, then single read to master 0
    cmd(1, 1'b1, 1'b0, 1'b1, 24'h000200);
    #1;
    chk("t3_ready_b", 32'(m_rdy), 32'b010);
    chk("t3_burst", 32'(s_bst), 1);
    step();
    clr();
    cmd(0, 1'b1, 1'b0, 1'b0, 24'h000300);
    #1;
    chk("t3_ready_s", 32'(m_rdy), 32'b001);
    step();
    clr();
    for (int k = 0; k < 9; k++) begin
      s_rsp = 1'b1;
      s_rdata = 16'h1000 + 16'(k);
      step();
      chk("t3_resp", 32'(m_rsp), (k < 8) ? 32'b010 : 32'b001);
      chk("t3_rdata", 32'(m_rdata), 32'h1000 + k);
    end
    s_rsp = 1'b0;
    chk("t3_empty", 32'(dut.w_count), 0);
    step();
    chk("t3_idle", 32'(m_rsp), 0);

    // 4: outstanding limit
    cmd(0, 1'b1, 1'b0, 1'b0, 24'h000400);
    repeat (4) step();
    cmd(2, 1'b0, 1'b1, 1'b0, 24'h000500);
    #1;
    chk("t4_wr_only", 32'(m_rdy), 32'b100);
    chk("t4_wr", 32'(s_wr), 1);
    step();
    vld[2] = 1'b0; wr[2] = 1'b0;
    #1;
    chk("t4_blocked", 32'(m_rdy), 0);
    chk("t4_no_valid", 32'(s_vld), 0);
    s_rsp = 1'b1; s_rdata = 16'hA5A5;
    #1;
    chk("t4_still_blk", 32'(m_rdy), 0);
    step();
    s_rsp = 1'b0;
    #1;
    chk("t4_resp", 32'(m_rsp), 32'b001);
    chk("t4_accept", 32'(m_rdy), 32'b001);
    step();
    clr();
    for (int k = 0; k < 4; k++) begin
      s_rsp = 1'b1;
      step();
      chk("t4_drain", 32'(m_rsp), 32'b001);
    end
    s_rsp = 1'b0;
    step();

    // 5: starvation promotion over HIPRI master 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmd(1, 1'b0, 1'b1, 1'b0, 24'h000031);
    cmd(0, 1'b0, 1'b1, 1'b0, 24'h000030);
    cyc = 100;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (c == 0) chk("t5_first", 32'(m_rdy), 32'b010);
      if (m_rdy[0]) begin
        cyc = c;
        break;
      end
      step();
    end
    chk("t5_starve_cyc", 32'(cyc), 64);
    step();
    chk("t5_hi_again", 32'(m_rdy), 32'b010);
    clr();
    step();

    // 6: spurious response, reset mid-burst, rd+wr collision
    s_rsp = 1'b1; s_rdata = 16'hDEAD;
    step();
    s_rsp = 1'b0;
    chk("t6_no_resp", 32'(m_rsp), 0);
    chk("t6_err", 32'(err), 1);
    step();
    step();
    chk("t6_err_hold", 32'(err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_err_clr", 32'(err), 0);
    cmd(1, 1'b1, 1'b0, 1'b1, 24'h000600);
    step();
    clr();
    s_rsp = 1'b1;
    repeat (3) step();
    chk("t6_mid_burst", 32'(m_rsp), 32'b010);
    s_rsp = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_rsp = 1'b1;
    step();
    s_rsp = 1'b0;
    chk("t6_tag_gone", 32'(m_rsp), 0);
    chk("t6_err_after", 32'(err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmd(0, 1'b1, 1'b1, 1'b0, 24'h000700);
    #1;
    chk("t6_rdwr_wr", 32'(s_wr), 1);
    chk("t6_rdwr_rd", 32'(s_rd), 0);
    step();
    clr();
    chk("t6_rdwr_err", 32'(err), 1);
    chk("t6_rdwr_notag", 32'(dut.w_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
